// File: rtl/gestor_alarma_pkg.sv
// Shared definitions for the temperature-alarm monitoring block.
//   estado_alarma_t : encoding of the alarm FSM, also exported on the
//                     'estado' port of gestor_alarma.
//   *_DEF           : default parameter values for gestor_alarma.
package pkg_monitoreo;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SOSPECHA = 2'd1,
    ALARMA   = 2'd2,
    RECUPERA = 2'd3
  } estado_alarma_t;

  localparam int N_CONFIRMA_DEF   = 4;
  localparam int N_RECUPERA_DEF   = 8;
  localparam int DIV_PARPADEO_DEF = 25_000_000;

endpackage

// File: rtl/gestor_alarma_divisor_parpadeo.sv
// Square-wave generator for the alarm LED.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (counter and output to 0)
//   reinicio : synchronous restart; clears the counter and forces output to 1
//   habilita : count enable
//   parpadeo : square wave, period 2*DIV clk cycles while enabled
module divisor_parpadeo #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic reinicio,
  input  logic habilita,
  output logic parpadeo
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOPE = CW'(DIV - 1);

  logic [CW-1:0] cuenta_reg;
  logic          parpadeo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cuenta_reg   <= '0;
      parpadeo_reg <= 1'b0;
    end else if (reinicio) begin
      cuenta_reg   <= '0;
      parpadeo_reg <= 1'b1;
    end else if (habilita) begin
      // Output holds each level for DIV cycles: counts 0..DIV-1, then toggles.
      if (cuenta_reg == TOPE) begin
        cuenta_reg   <= '0;
        parpadeo_reg <= ~parpadeo_reg;
      end else begin
        cuenta_reg <= cuenta_reg + CW'(1);
      end
    end
  end

  assign parpadeo = parpadeo_reg;

endmodule

// File: rtl/gestor_alarma.sv
// Debounced alarm manager for the temperature comparator's out-of-range flag.
// N_CONFIRMA consecutive out-of-range samples raise the alarm, N_RECUPERA
// consecutive in-range samples clear it. Drives a blinking/steady LED with
// operator acknowledge and counts alarm entries (saturating).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   muestra_valida    : one-cycle strobe, new sample available
//   fuera_rango       : comparator flag, used only with muestra_valida
//   reconocer         : operator acknowledge
//   alarma_activa     : 1 in ALARMA or RECUPERA
//   led_alarma        : alarm LED
//   estado            : current FSM state (estado_alarma_t)
//   contador_eventos  : number of alarm entries, saturating
module gestor_alarma
  import pkg_monitoreo::*;
#(
  parameter int N_CONFIRMA    = N_CONFIRMA_DEF,
  parameter int N_RECUPERA    = N_RECUPERA_DEF,
  parameter int DIV_PARPADEO  = DIV_PARPADEO_DEF,
  parameter int ANCHO_EVENTOS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     muestra_valida,
  input  logic                     fuera_rango,
  input  logic                     reconocer,
  output logic                     alarma_activa,
  output logic                     led_alarma,
  output logic [1:0]               estado,
  output logic [ANCHO_EVENTOS-1:0] contador_eventos
);

  localparam int N_MAX = (N_CONFIRMA > N_RECUPERA) ? N_CONFIRMA : N_RECUPERA;
  localparam int CW    = $clog2(N_MAX + 1);
  localparam logic [CW-1:0] ULT_CONFIRMA = CW'(N_CONFIRMA - 1);
  localparam logic [CW-1:0] ULT_RECUPERA = CW'(N_RECUPERA - 1);

  estado_alarma_t           estado_reg, estado_next;
  logic [CW-1:0]            cnt_reg, cnt_next;
  logic [ANCHO_EVENTOS-1:0] eventos_reg, eventos_next;
  logic                     reconocida_reg, reconocida_next;
  logic                     entra_alarma;
  logic                     parpadeo;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_reg     <= NORMAL;
      cnt_reg        <= '0;
      eventos_reg    <= '0;
      reconocida_reg <= 1'b0;
    end else begin
      estado_reg     <= estado_next;
      cnt_reg        <= cnt_next;
      eventos_reg    <= eventos_next;
      reconocida_reg <= reconocida_next;
    end
  end

  always_comb begin
    estado_next  = estado_reg;
    cnt_next     = cnt_reg;
    entra_alarma = 1'b0;
    if (muestra_valida) begin
      case (estado_reg)
        NORMAL: begin
          if (fuera_rango) begin
            estado_next = SOSPECHA;
            cnt_next    = CW'(1);
          end
        end
        SOSPECHA: begin
          if (!fuera_rango) begin
            estado_next = NORMAL;
            cnt_next    = '0;
          end else if (cnt_reg == ULT_CONFIRMA) begin
            estado_next  = ALARMA;
            cnt_next     = '0;
            entra_alarma = 1'b1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        ALARMA: begin
          if (fuera_rango) begin
            cnt_next = '0;
          end else begin
            estado_next = RECUPERA;
            cnt_next    = CW'(1);
          end
        end
        RECUPERA: begin
          // A bounce back to ALARMA is the same event, not a new one.
          if (fuera_rango) begin
            estado_next = ALARMA;
            cnt_next    = '0;
          end else if (cnt_reg == ULT_RECUPERA) begin
            estado_next = NORMAL;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: begin
          estado_next = NORMAL;
          cnt_next    = '0;
        end
      endcase
    end
  end

  always_comb begin
    eventos_next = eventos_reg;
    if (entra_alarma && (eventos_reg != '1))
      eventos_next = eventos_reg + ANCHO_EVENTOS'(1);
  end

  // Acknowledge only counts while the registered state is already an alarm
  // state; leaving for NORMAL takes priority so a new alarm starts unacknowledged.
  always_comb begin
    reconocida_next = reconocida_reg;
    if (reconocer && alarma_activa)
      reconocida_next = 1'b1;
    if ((estado_next == NORMAL) && (estado_reg != NORMAL))
      reconocida_next = 1'b0;
  end

  assign alarma_activa = (estado_reg == ALARMA) || (estado_reg == RECUPERA);

  divisor_parpadeo #(
    .DIV (DIV_PARPADEO)
  ) u_divisor (
    .clk      (clk),
    .rst      (rst),
    .reinicio (entra_alarma),
    .habilita (alarma_activa),
    .parpadeo (parpadeo)
  );

  assign led_alarma       = alarma_activa & (reconocida_reg | parpadeo);
  assign estado           = estado_reg;
  assign contador_eventos = eventos_reg;

endmodule

// File: tb/tb_gestor_alarma.sv
// Self-checking bench for gestor_alarma: directed scenarios with literal
// expectations, then randomized traffic, all cross-checked every cycle
// against a run-length based reference model.
module tb_gestor_alarma;

  localparam int NC  = 4;
  localparam int NR  = 8;
  localparam int DIV = 4;
  localparam int AE  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          muestra_valida = 1'b0;
  logic          fuera_rango = 1'b0;
  logic          reconocer = 1'b0;
  logic          alarma_activa;
  logic          led_alarma;
  logic [1:0]    estado;
  logic [AE-1:0] contador_eventos;

  int checks = 0;
  int errors = 0;

  gestor_alarma #(
    .N_CONFIRMA    (NC),
    .N_RECUPERA    (NR),
    .DIV_PARPADEO  (DIV),
    .ANCHO_EVENTOS (AE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .muestra_valida   (muestra_valida),
    .fuera_rango      (fuera_rango),
    .reconocer        (reconocer),
    .alarma_activa    (alarma_activa),
    .led_alarma       (led_alarma),
    .estado           (estado),
    .contador_eventos (contador_eventos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, req);
    end
  endtask

  // ---------------- reference model ----------------
  // The alarm is described by runs of consecutive samples: outside alarm,
  // the length of the current out-of-range run; inside, the length of the
  // current in-range run. Blink phase is clk cycles since alarm entry.
  bit m_alarm  = 0;
  int out_run  = 0;
  int in_run   = 0;
  int m_events = 0;
  int m_since  = 0;
  bit m_acked  = 0;
  bit armed    = 0;

  function automatic int m_estado();
    if (!m_alarm) return (out_run == 0) ? 0 : 1;
    return (in_run == 0) ? 2 : 3;
  endfunction

  function automatic int m_led();
    if (!m_alarm) return 0;
    if (m_acked) return 1;
    return (((m_since / DIV) % 2) == 0) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_alarm = 0; out_run = 0; in_run = 0; m_events = 0;
      m_since = 0; m_acked = 0; armed = 1;
    end else begin
      if (reconocer && m_alarm) m_acked = 1;
      if (m_alarm) m_since++;
      if (muestra_valida) begin
        if (!m_alarm) begin
          out_run = fuera_rango ? out_run + 1 : 0;
          if (out_run == NC) begin
            m_alarm = 1; out_run = 0; in_run = 0; m_since = 0;
            if (m_events < (1 << AE) - 1) m_events++;
          end
        end else begin
          in_run = fuera_rango ? 0 : in_run + 1;
          if (in_run == NR) begin
            m_alarm = 0; in_run = 0; out_run = 0; m_acked = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_estado", int'(estado), m_estado());
      chk("m_activa", int'(alarma_activa), int'(m_alarm));
      chk("m_led", int'(led_alarma), m_led());
      chk("m_eventos", int'(contador_eventos), m_events);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit f);
    muestra_valida = 1'b1;
    fuera_rango    = f;
    @(posedge clk);
    #1;
    muestra_valida = 1'b0;
    fuera_rango    = 1'b0;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};
  int glitch [7]  = '{1, 1, 1, 0, 1, 1, 1};

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("reset_estado", int'(estado), 0);
    chk("reset_activa", int'(alarma_activa), 0);
    chk("reset_led", int'(led_alarma), 0);
    chk("reset_eventos", int'(contador_eventos), 0);
    $display("reset done estado=%0d", estado);

    // Confirmation with 3 idle cycles between strobes
    for (int i = 1; i <= 4; i++) begin
      strobe(1'b1);
      if (i < 4) begin
        chk("conf_estado", int'(estado), 1);
        idle(3);
      end
    end
    chk("conf_estado_alarma", int'(estado), 2);
    chk("conf_activa", int'(alarma_activa), 1);
    chk("conf_eventos", int'(contador_eventos), 1);
    $display("confirmation estado=%0d eventos=%0d", estado, contador_eventos);

    // Blink: 1 for 4 cycles, 0 for 4, 1 again
    chk("blink_0", int'(led_alarma), 1);
    idle(4);
    chk("blink_1", int'(led_alarma), 0);
    idle(4);
    chk("blink_2", int'(led_alarma), 1);
    $display("blink led=%0d", led_alarma);

    // Acknowledge: steady LED
    reconocer = 1'b1;
    idle(1);
    reconocer = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("ack_steady", int'(led_alarma), 1);
    end
    $display("acknowledge led=%0d", led_alarma);

    // Recovery with a bounce
    for (int i = 0; i < 5; i++) begin
      strobe(1'b0);
      chk("rec_estado", int'(estado), 3);
      chk("rec_led", int'(led_alarma), 1);
    end
    strobe(1'b1);
    chk("bounce_estado", int'(estado), 2);
    for (int i = 1; i <= 8; i++) begin
      strobe(1'b0);
      chk("rec2_estado", int'(estado), (i < 8) ? 3 : 0);
    end
    chk("rec_led_off", int'(led_alarma), 0);
    chk("rec_activa_off", int'(alarma_activa), 0);
    chk("rec_eventos", int'(contador_eventos), 1);
    $display("recovery estado=%0d eventos=%0d", estado, contador_eventos);

    // Acknowledge in NORMAL must not carry into the next alarm
    reconocer = 1'b1;
    idle(2);
    reconocer = 1'b0;
    for (int i = 0; i < 4; i++) strobe(1'b1);
    chk("noack_eventos", int'(contador_eventos), 2);
    chk("noack_led_on", int'(led_alarma), 1);
    idle(4);
    chk("noack_led_blink", int'(led_alarma), 0);
    $display("ack-in-normal ignored led=%0d", led_alarma);
    for (int i = 0; i < 8; i++) strobe(1'b0);
    chk("back_normal", int'(estado), 0);

    // Glitch rejection
    for (int i = 0; i < 7; i++) begin
      strobe(glitch[i][0]);
      chk("glitch_no_alarm", int'(estado == 2'd2), 0);
      if (i == 3) chk("glitch_normal", int'(estado), 0);
    end
    chk("glitch_eventos", int'(contador_eventos), 2);
    strobe(1'b0);
    $display("glitch rejection estado=%0d", estado);

    // Reset mid-recovery with internal count 5
    for (int i = 0; i < 4; i++) strobe(1'b1);
    for (int i = 0; i < 5; i++) strobe(1'b0);
    chk("pre_rst_estado", int'(estado), 3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_estado", int'(estado), 0);
    chk("rst_mid_activa", int'(alarma_activa), 0);
    chk("rst_mid_led", int'(led_alarma), 0);
    chk("rst_mid_eventos", int'(contador_eventos), 0);
    strobe(1'b1);
    chk("rst_then_sospecha", int'(estado), 1);
    strobe(1'b0);
    $display("reset mid-operation estado=%0d", estado);

    // Saturation with a 2-bit event counter
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) strobe(1'b1);
      chk("sat_eventos", int'(contador_eventos), sat_exp[k]);
      for (int i = 0; i < 8; i++) strobe(1'b0);
      $display("saturation cycle %0d eventos=%0d", k, contador_eventos);
    end

    // Randomized traffic with run-length bias so alarms actually happen
    begin
      bit f = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        rst            = ($urandom_range(0, 999) == 0);
        muestra_valida = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) f = ~f;
        fuera_rango    = f;
        reconocer      = ($urandom_range(0, 39) == 0);
        idle(1);
      end
      rst = 1'b0; muestra_valida = 1'b0; fuera_rango = 1'b0; reconocer = 1'b0;
      idle(2);
      $display("random phase done estado=%0d eventos=%0d", estado, contador_eventos);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gestor_alarma.md
Name: gestor_alarma

Overview:
Consumer side of the temperature comparator's out-of-range flag. Samples `fuera_rango` on each valid temperature sample and debounces it into a latched alarm: N consecutive out-of-range samples raise it, M consecutive in-range samples clear it. Drives a blinking or steady alarm LED with an operator acknowledge input, and counts alarm events. Sits between the comparator and the board LEDs/status outputs.

Parameters:
- N_CONFIRMA, 4, consecutive out-of-range valid samples needed to enter alarm; must be >= 2.
- N_RECUPERA, 8, consecutive in-range valid samples needed to clear alarm; must be >= 2.
- DIV_PARPADEO, 25_000_000, clock cycles per LED half-period; must be >= 2.
- ANCHO_EVENTOS, 8, width of the alarm event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- muestra_valida  in  1  one-cycle strobe: a new temperature sample has been registered.
- fuera_rango  in  1  comparator flag; sampled only when muestra_valida=1.
- reconocer  in  1  operator acknowledge, level or pulse.
- alarma_activa  out  1  1 while in ALARMA or RECUPERA.
- led_alarma  out  1  alarm LED.
- estado  out  2  current FSM state (estado_alarma_t encoding).
- contador_eventos  out  ANCHO_EVENTOS  number of alarm entries; saturating.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - estado=NORMAL, internal sample count=0, reconocida=0, blink counter=0.
  - All outputs are 0 on the following cycle, including contador_eventos.
  - Reset mid-alarm behaves identically; no state is retained.
- Sample gating: the FSM and sample count advance only on cycles with muestra_valida=1. With muestra_valida=0, fuera_rango is ignored and the state holds.
- States and encoding: NORMAL=0, SOSPECHA=1, ALARMA=2, RECUPERA=3.
- Transitions (all on valid samples, with cnt = internal sample count):
  - NORMAL, fuera=1: go to SOSPECHA, cnt=1.
  - NORMAL, fuera=0: stay.
  - SOSPECHA, fuera=1: if cnt+1==N_CONFIRMA, go to ALARMA, cnt=0, contador_eventos+1 (saturating at 2^ANCHO_EVENTOS-1); otherwise cnt+1.
  - SOSPECHA, fuera=0: go to NORMAL, cnt=0.
  - ALARMA, fuera=0: go to RECUPERA, cnt=1.
  - ALARMA, fuera=1: stay, cnt=0.
  - RECUPERA, fuera=0: if cnt+1==N_RECUPERA, go to NORMAL, cnt=0; otherwise cnt+1.
  - RECUPERA, fuera=1: go back to ALARMA, cnt=0. This is not a new event; the counter does not increment.
- Latency: estado and alarma_activa are registered. alarma_activa rises on the clk edge that samples the N_CONFIRMA-th consecutive out-of-range strobe, so it is visible in the next cycle. Deassertion follows the same rule for N_RECUPERA.
- Acknowledge:
  - reconocida is set on any cycle with reconocer=1 while alarma_activa=1 (registered state).
  - reconocida is cleared on entry to NORMAL.
  - reconocer while in NORMAL or SOSPECHA is ignored. This includes the same cycle as the SOSPECHA to ALARMA transition.
  - A RECUPERA to ALARMA bounce keeps reconocida.
- LED:
  - led_alarma=0 when alarma_activa=0.
  - Steady 1 when alarma_activa=1 and reconocida=1.
  - Otherwise it blinks: forced to 1 and blink counter cleared on SOSPECHA to ALARMA entry, then toggles every DIV_PARPADEO cycles, counted on clk rather than on valid samples.
  - The blink counter wraps at DIV_PARPADEO-1 and keeps running through RECUPERA.
- Arithmetic:
  - Sample count width is $clog2(max(N_CONFIRMA,N_RECUPERA)+1).
  - The event counter holds at all-ones and never wraps.

Decomposition:
- Package pkg_monitoreo contains:
  - typedef enum logic [1:0] estado_alarma_t {NORMAL, SOSPECHA, ALARMA, RECUPERA};
  - default constants N_CONFIRMA_DEF, N_RECUPERA_DEF, DIV_PARPADEO_DEF.
- One sub-module: divisor_parpadeo.
  - Parameter DIV.
  - Inputs clk, rst, reinicio (synchronous clear that forces the output to 1), habilita.
  - Output parpadeo, a square wave with period 2*DIV clk cycles.

Test Plan (bench sets DIV_PARPADEO=4, N_CONFIRMA=4, N_RECUPERA=8):
- Confirmation: 4 strobes with fuera=1, 3 idle cycles between them -> estado goes 1 after strobe 1, 2 after strobe 4; alarma_activa=1 one cycle after strobe 4; contador_eventos=1.
- Glitch rejection: fuera pattern 1,1,1,0,1,1,1 on strobes -> estado never reaches 2; returns to 0 after the 4th strobe; contador_eventos=0.
- Recovery with bounce: in ALARMA, strobes fuera=0 x5, 1, then 0 x8 -> 2 to 3, back to 2 on the 6th strobe, 3, then 0 after the 8th clean strobe; contador_eventos unchanged.
- Blink and acknowledge: in ALARMA with no strobes -> led_alarma toggles 1,0,1 every 4 clk cycles. Pulse reconocer=1 for one cycle -> led_alarma steady 1 until NORMAL, then 0. reconocer during NORMAL -> no effect on the next alarm, which blinks.
- Saturation: ANCHO_EVENTOS=2, drive 5 full alarm/recovery cycles -> contador_eventos reads 1,2,3,3,3.
- Reset mid-operation: rst=1 for one cycle in RECUPERA with cnt=5 -> next cycle estado=0, all outputs 0. A subsequent single fuera=1 strobe yields SOSPECHA, not ALARMA.
